// File: rtl/vb_stream_encoder_pkg.sv
// Shared definitions for the variable-byte stream encoder: modes, FSM states and
// the group-count helper used on the FIFO head word.
package vb_stream_encoder_pkg;

  localparam logic MODE_MSB_FIRST = 1'b0;
  localparam logic MODE_LEB128    = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  function automatic int unsigned vb_maxb(input int unsigned data_w);
    return (data_w + 6) / 7;
  endfunction

  // Number of 7-bit groups needed for a word; zero still takes one byte.
  function automatic logic [3:0] vb_len(input logic [63:0] d);
    logic [3:0] n;
    n = 4'd1;
    for (int g = 1; g < 10; g++) begin
      if ((d >> (7 * g)) != 64'd0) n = 4'(g + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/vb_stream_encoder_fifo.sv
// Word FIFO for the encoder: power-of-two depth, pointers carry an extra wrap
// bit so full and empty are told apart without a separate counter.
module vb_stream_encoder_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/vb_stream_encoder.sv
// Variable-byte encoder: buffers words in a FIFO and streams each one out as
// 1..MAXB bytes, MSB-first with stop bit or LSB-first LEB128 per word.
module vb_stream_encoder
  import vb_stream_encoder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  localparam int MAXB  = vb_maxb(DATA_W);
  localparam int IDX_W = $clog2(MAXB + 1);
  localparam int PAD_W = MAXB * 7;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state;
  state_t             state_nx;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_W:0]    fifo_head;
  logic               push;
  logic               pop;
  logic [3:0]         head_len;

  logic [DATA_W-1:0]  word_p1;
  logic               mode_p1;
  logic [IDX_W-1:0]   nbytes_p1;
  logic [IDX_W-1:0]   idx_p1;

  logic               last_byte;
  logic               accept;
  logic [IDX_W-1:0]   grp_sel;
  logic [PAD_W-1:0]   word_pad;
  logic [6:0]         group;

  // in_ready looks only at registered FIFO state, so a pop never frees a slot early.
  assign in_ready = !fifo_full && !reset;
  assign push     = in_valid && in_ready;
  assign pop      = (state == ST_LOAD);

  vb_stream_encoder_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data ({in_mode, in_data}),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_len  = vb_len(64'(fifo_head[DATA_W-1:0]));
  assign last_byte = (idx_p1 == nbytes_p1 - IDX_ONE);
  assign accept    = (state == ST_EMIT) && out_ready;
  assign busy      = !fifo_empty || (state != ST_IDLE);

  // Stage p1: word captured at LOAD, held for the whole emission
  always_ff @(posedge clk) begin
    if (pop) begin
      word_p1   <= fifo_head[DATA_W-1:0];
      mode_p1   <= fifo_head[DATA_W];
      nbytes_p1 <= IDX_W'(head_len);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx_p1     <= '0;
      word_count <= '0;
    end else begin
      state <= state_nx;
      if (pop) begin
        idx_p1 <= '0;
      end else if (accept) begin
        if (last_byte) word_count <= word_count + CNT_ONE;
        else           idx_p1     <= idx_p1 + IDX_ONE;
      end
    end
  end

  // Empty flag is registered, so a word pushed this cycle waits for IDLE->LOAD.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (!fifo_empty) state_nx = ST_LOAD;
      ST_LOAD: state_nx = ST_EMIT;
      ST_EMIT: if (accept && last_byte) state_nx = fifo_empty ? ST_IDLE : ST_LOAD;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Stage out: byte mux, MSB-first walks groups downward, LEB128 upward
  always_comb begin
    word_pad  = PAD_W'(word_p1);
    grp_sel   = (mode_p1 == MODE_MSB_FIRST) ? (nbytes_p1 - idx_p1 - IDX_ONE) : idx_p1;
    group     = 7'(word_pad >> (7 * int'(grp_sel)));
    out_valid = (state == ST_EMIT);
    out_last  = 1'b0;
    out_byte  = 8'h00;
    if (out_valid) begin
      out_last = last_byte;
      if (mode_p1 == MODE_MSB_FIRST) out_byte = {last_byte, group};
      else                           out_byte = {!last_byte, group};
    end
  end

endmodule

// File: tb/tb_vb_stream_encoder.sv
// Self-checking bench for vb_stream_encoder: fixed vector table, latency,
// back-pressure/full, mid-word reset, and randomized traffic against a model.
module tb_vb_stream_encoder;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_byte;
  logic              out_last;
  logic              busy;
  logic [CNT_W-1:0]  word_count;

  vb_stream_encoder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last),
    .busy(busy), .word_count(word_count)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int exp_wc = 0;
  logic rdy_mode = 1'b0;
  logic rdy_val  = 1'b0;

  logic [8:0] got[$];
  int         got_cyc[$];
  logic [8:0] exp_q[$];

  typedef struct {
    logic [31:0] data;
    logic        mode;
    int          n;
    logic [39:0] bytes;
  } vec_t;

  vec_t tbl[10];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference: split into base-128 digits, then order and flag per mode.
  function automatic void model(input logic [31:0] d, input logic m);
    logic [7:0] g[$];
    longint unsigned v;
    int n;
    logic [7:0] b;
    v = 64'(d);
    do begin
      g.push_back(8'(v % 128));
      v = v / 128;
    end while (v != 0);
    n = g.size();
    for (int i = 0; i < n; i++) begin
      if (m) b = g[i] | ((i != n - 1) ? 8'h80 : 8'h00);
      else   b = g[n - 1 - i] | ((i == n - 1) ? 8'h80 : 8'h00);
      exp_q.push_back({(i == n - 1), b});
    end
  endfunction

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // Monitor: record accepted bytes and check stall stability.
  logic       prev_stall = 1'b0;
  logic       prev_reset = 1'b1;
  logic [7:0] prev_byte  = 8'h00;
  logic       prev_last  = 1'b0;
  always @(negedge clk) begin
    if (prev_stall && !prev_reset) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_byte", 64'(out_byte), 64'(prev_byte));
      chk("stall_last", 64'(out_last), 64'(prev_last));
    end
    if (out_valid && out_ready && !reset) begin
      got.push_back({out_last, out_byte});
      got_cyc.push_back(cyc);
    end
    prev_stall = out_valid && !out_ready;
    prev_reset = reset;
    prev_byte  = out_byte;
    prev_last  = out_last;
  end

  task automatic push(input logic [31:0] d, input logic m);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("push_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    int t;
    t = 0;
    while (got.size() < n && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("byte_count", 64'(got.size()), 64'(n));
  endtask

  task automatic compare_exp(input string name, input bit gaps);
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk(name, 64'(got[i]), 64'(exp_q[i]));
      if (gaps && i > 0)
        chk("byte_spacing", 64'(got_cyc[i] - got_cyc[i-1]), got[i-1][8] ? 64'd2 : 64'd1);
    end
  endtask

  initial begin
    logic [31:0] fw[6];
    logic        fm[6];
    int acc;
    int t;

    tbl[0] = '{32'h0000_0000, 1'b0, 1, 40'h00_0000_0080};
    tbl[1] = '{32'h0000_0000, 1'b1, 1, 40'h00_0000_0000};
    tbl[2] = '{32'h0000_0082, 1'b0, 2, 40'h00_0000_8201};
    tbl[3] = '{32'h0000_0082, 1'b1, 2, 40'h00_0000_0182};
    tbl[4] = '{32'hFFFF_FFFF, 1'b0, 5, 40'hFF_7F7F_7F0F};
    tbl[5] = '{32'hFFFF_FFFF, 1'b1, 5, 40'h0F_FFFF_FFFF};
    tbl[6] = '{32'h0000_0005, 1'b0, 1, 40'h00_0000_0085};
    tbl[7] = '{32'h0000_0080, 1'b1, 2, 40'h00_0000_0180};
    tbl[8] = '{32'h0000_3FFF, 1'b0, 2, 40'h00_0000_FF7F};
    tbl[9] = '{32'h0000_4000, 1'b1, 3, 40'h00_0001_8080};

    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;

    // Reset behaviour
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_byte", 64'(out_byte), 64'd0);
    chk("reset_out_last", 64'(out_last), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_word_count", 64'(word_count), 64'd0);
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Table vectors, sink always ready
    rdy_val = 1'b1;
    for (int v = 0; v < 10; v++) begin
      got.delete(); got_cyc.delete();
      push(tbl[v].data, tbl[v].mode);
      wait_bytes(tbl[v].n);
      exp_wc++;
      for (int i = 0; i < tbl[v].n && i < got.size(); i++) begin
        logic [39:0] bv;
        bv = tbl[v].bytes;
        chk($sformatf("tbl%0d_byte%0d", v, i), 64'(got[i][7:0]), 64'(bv[8*i +: 8]));
        chk($sformatf("tbl%0d_last%0d", v, i), 64'(got[i][8]), (i == tbl[v].n - 1) ? 64'd1 : 64'd0);
      end
      chk($sformatf("tbl%0d_word_count", v), 64'(word_count), 64'(exp_wc % 16));
      chk($sformatf("tbl%0d_idle", v), 64'(busy), 64'd0);
    end

    // First-byte latency: pushed at edge t, out_valid after edge t+2
    got.delete(); got_cyc.delete();
    push(32'h0000_0082, 1'b1);
    @(negedge clk); chk("latency_t0", 64'(out_valid), 64'd0);
    @(negedge clk); chk("latency_t1", 64'(out_valid), 64'd0);
    @(negedge clk); chk("latency_t2", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    wait_bytes(2);
    exp_wc++;

    // Back-pressure: sink stalled, keep offering words until FIFO fills
    got.delete(); got_cyc.delete(); exp_q.delete();
    rdy_val = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      fw[i] = $urandom >> $urandom_range(0, 31);
      fm[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 5; i++) model(fw[i], fm[i]);
    acc = 0;
    in_valid = 1'b1; in_data = fw[0]; in_mode = fm[0];
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      if (acc < 6) begin
        in_data = fw[acc]; in_mode = fm[acc];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("full_accepted", 64'(acc), 64'd5);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    chk("full_no_output", 64'(got.size()), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rdy_val = 1'b1;
    wait_bytes(exp_q.size());
    compare_exp("full_drain", 1'b1);
    exp_wc += 5;
    chk("full_word_count", 64'(word_count), 64'(exp_wc % 16));

    // Reset during byte 3 of 0xFFFFFFFF
    got.delete(); got_cyc.delete();
    rdy_val = 1'b0;
    @(posedge clk); #1;
    push(32'hFFFF_FFFF, 1'b0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clk); #1; t++;
    end
    rdy_val = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rdy_val = 1'b0;
    @(negedge clk);
    chk("midword_byte3", 64'(out_byte), 64'h7F);
    chk("midword_accepted", 64'(got.size()), 64'd2);
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    chk("midword_reset_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("midword_out_valid", 64'(out_valid), 64'd0);
    chk("midword_word_count", 64'(word_count), 64'd0);
    chk("midword_busy", 64'(busy), 64'd0);
    chk("midword_in_ready", 64'(in_ready), 64'd1);
    exp_wc = 0;
    got.delete(); got_cyc.delete();
    rdy_val = 1'b1;
    @(posedge clk); #1;
    push(32'h0000_0005, 1'b0);
    wait_bytes(1);
    repeat (6) @(posedge clk);
    #1;
    chk("after_reset_nbytes", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("after_reset_byte", 64'(got[0]), 64'h185);
    exp_wc++;
    chk("after_reset_word_count", 64'(word_count), 64'(exp_wc));

    // Randomized traffic with random sink stalls
    got.delete(); got_cyc.delete(); exp_q.delete();
    rdy_mode = 1'b1;
    push(32'hFFFF_FFFF, 1'b0);
    model(32'hFFFF_FFFF, 1'b0);
    push(32'hFFFF_FFFF, 1'b1);
    model(32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] d;
      logic        m;
      d = $urandom >> $urandom_range(0, 31);
      m = 1'($urandom_range(0, 1));
      model(d, m);
      push(d, m);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
      #1;
    end
    wait_bytes(exp_q.size());
    compare_exp("random_byte", 1'b0);
    exp_wc += 42;
    rdy_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("random_word_count", 64'(word_count), 64'(exp_wc % 16));
    chk("random_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
